// File: rtl/apb_master_fsm.sv
// APB master: pops one {rw, addr, data} entry from the transaction FIFO and
// runs it as a single APB transfer, reporting read data and completion status.
module apb_master_fsm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ENTRY_W = 1 + ADDR_W + DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [ENTRY_W-1:0] fifo_dout,
    output logic               psel,
    output logic               penable,
    output logic               pwrite,
    output logic [ADDR_W-1:0]  paddr,
    output logic [DATA_W-1:0]  pwdata,
    input  logic [DATA_W-1:0]  prdata,
    input  logic               pready,
    input  logic               pslverr,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               done,
    output logic               err,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // FIFO side: fifo_rd_en is a request, fifo_dout is valid the cycle after it.
    // APB side: psel opens SETUP, penable marks ACCESS, a transfer ends on the
    // first ACCESS cycle that samples pready high (or on timeout).

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETUP  = 2'd2,
        S_ACCESS = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d    = state_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        rd_data_d  = rd_data_q;
        cnt_d      = cnt_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pwrite_d = fifo_dout[ADDR_W+DATA_W];
                paddr_d  = fifo_dout[DATA_W +: ADDR_W];
                pwdata_d = fifo_dout[DATA_W-1:0];
                cnt_d    = '0;
                state_d  = S_SETUP;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    done_d  = 1'b1;
                    err_d   = pslverr;
                    state_d = S_IDLE;
                    // Read data is returned even when the slave flags an error.
                    if (!pwrite_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = prdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Pops only from IDLE, and never while reset is held.
    assign fifo_rd_en = (state_q == S_IDLE) && !fifo_empty && !rst;
    assign psel       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign penable    = (state_q == S_ACCESS);
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: FIFO model feeding the DUT, an APB slave driven per
// transaction, and a transaction-level expectation model checked at each step.
module tb_apb_master_fsm;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int TIMEOUT = 16;

    logic               clk;
    logic               rst;
    logic               fifo_empty;
    logic               fifo_rd_en;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               psel, penable, pwrite;
    logic [ADDR_W-1:0]  paddr;
    logic [DATA_W-1:0]  pwdata, prdata, rd_data;
    logic               pready, pslverr;
    logic               rd_valid, done, err, busy;
    logic [1:0]         dbg_state;

    apb_master_fsm #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ENTRY_W(ENTRY_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    // FIFO model: entries written by the stimulus, popped on fifo_rd_en
    logic [ENTRY_W-1:0] fifo_mem [0:255];
    int push_cnt = 0;
    int pop_cnt = 0;
    int overreads = 0;

    assign fifo_empty = (push_cnt == pop_cnt);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (push_cnt == pop_cnt) begin
                overreads <= overreads + 1;
            end else begin
                fifo_dout <= fifo_mem[pop_cnt];
                pop_cnt   <= pop_cnt + 1;
            end
        end
    end

    // Transaction descriptors and reference state
    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                waits;
        logic              slverr;
        logic [DATA_W-1:0] rdata;
    } txn_t;

    txn_t              stim_q[$];
    logic [DATA_W-1:0] exp_rd_data = '0;
    int                tests = 0;
    int                fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        fifo_mem[push_cnt] = {rw, a, d};
        push_cnt++;
    endtask

    task automatic push_txn(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input int waits, input logic slverr, input logic [DATA_W-1:0] rdata);
        txn_t t;
        t.rw = rw; t.addr = a; t.data = d; t.waits = waits; t.slverr = slverr; t.rdata = rdata;
        push_entry(rw, a, d);
        stim_q.push_back(t);
    endtask

    // Runs until n_txn transfers complete; entered and left on a falling edge.
    task automatic run_drain(input int n_txn);
        int   cyc = 0;
        int   n_done = 0;
        int   acc = 0;
        int   exp_acc;
        bit   active = 0;
        bit   timed_out;
        int   pop_cyc_q[$];
        int   budget = 40 * n_txn + 20;
        txn_t cur;
        while (n_done < n_txn && cyc < budget) begin
            #1;
            if (fifo_rd_en) begin
                check("pop_only_when_idle", busy, 1'b0);
                pop_cyc_q.push_back(cyc);
            end
            if (psel && !penable) begin
                if (!active) begin
                    check("setup_has_txn", stim_q.size() > 0, 1'b1);
                    check("setup_has_pop", pop_cyc_q.size() > 0, 1'b1);
                    if (stim_q.size() > 0) cur = stim_q.pop_front();
                    if (pop_cyc_q.size() > 0) check("pop_to_psel_cycles", cyc - pop_cyc_q.pop_front(), 2);
                    active = 1;
                    acc = 0;
                end
                check("setup_paddr", paddr, cur.addr);
                check("setup_pwrite", pwrite, cur.rw);
                check("setup_pwdata", pwdata, cur.data);
            end else if (psel && penable) begin
                check("access_active", active, 1'b1);
                check("access_paddr", paddr, cur.addr);
                check("access_pwrite", pwrite, cur.rw);
                check("access_pwdata", pwdata, cur.data);
                pready  = (acc == cur.waits);
                pslverr = pready ? cur.slverr : 1'($urandom_range(0, 1));
                prdata  = pready ? cur.rdata : DATA_W'($urandom);
                acc++;
            end else begin
                pready  = 1'($urandom_range(0, 1));
                pslverr = 1'($urandom_range(0, 1));
                prdata  = DATA_W'($urandom);
                if (done) begin
                    check("done_has_txn", active, 1'b1);
                    timed_out = (cur.waits >= TIMEOUT);
                    exp_acc   = timed_out ? TIMEOUT : cur.waits + 1;
                    if (!timed_out && !cur.rw) exp_rd_data = cur.rdata;
                    check("access_cycles", acc, exp_acc);
                    check("done_err", err, timed_out ? 1'b1 : cur.slverr);
                    check("done_rd_valid", rd_valid, (!timed_out && !cur.rw));
                    check("done_rd_data", rd_data, exp_rd_data);
                    active = 0;
                    n_done++;
                end else begin
                    check("idle_no_err", err, 1'b0);
                    check("idle_no_rd_valid", rd_valid, 1'b0);
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("drain_completed", n_done, n_txn);
    endtask

    initial begin
        rst = 1'b1; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, '0);
        check("rst_pwdata", pwdata, '0);
        check("rst_rd_data", rd_data, '0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // single write, zero wait
        push_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, '0);
        run_drain(1);
        // read with 3 wait cycles
        push_txn(1'b0, 32'h0000_0020, 32'h0, 3, 1'b0, 32'h1234_5678);
        run_drain(1);
        // read with slave error
        push_txn(1'b0, 32'h0000_0030, 32'h0, 0, 1'b1, 32'hCAFE_0030);
        run_drain(1);
        // timeout, followed by an entry that must still run
        push_txn(1'b0, 32'h0000_0034, 32'h0, TIMEOUT + 5, 1'b0, 32'hBAD0_BAD0);
        push_txn(1'b1, 32'h0000_0038, 32'h0101_0101, 1, 1'b0, '0);
        run_drain(2);
        // back-to-back writes
        push_txn(1'b1, 32'h0, 32'hA000_0000, 0, 1'b0, '0);
        push_txn(1'b1, 32'h4, 32'hA000_0004, 0, 1'b0, '0);
        push_txn(1'b1, 32'h8, 32'hA000_0008, 0, 1'b0, '0);
        run_drain(3);

        // randomized batches
        for (int b = 0; b < 12; b++) begin
            int n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                int w = ($urandom_range(0, 7) == 0) ? TIMEOUT + 2 : $urandom_range(0, 4);
                push_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                         w, 1'($urandom_range(0, 1)), DATA_W'($urandom));
            end
            run_drain(n);
        end

        // reset in the middle of ACCESS
        pready = 1'b0;
        push_entry(1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (penable) break;
            @(negedge clk);
        end
        check("pre_rst_penable", penable, 1'b1);
        push_txn(1'b1, 32'h0000_0044, 32'h5555_5555, 0, 1'b0, '0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        exp_rd_data = '0;
        check("mid_rst_psel", psel, 1'b0);
        check("mid_rst_penable", penable, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_rd_valid", rd_valid, 1'b0);
        check("mid_rst_paddr", paddr, '0);
        check("mid_rst_pwdata", pwdata, '0);
        check("mid_rst_pwrite", pwrite, 1'b0);
        check("mid_rst_rd_data", rd_data, exp_rd_data);
        check("mid_rst_rd_en", fifo_rd_en, 1'b0);
        @(negedge clk);
        #1;
        check("held_rst_rd_en", fifo_rd_en, 1'b0);
        check("held_rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_drain(1);

        check("fifo_all_popped", pop_cnt, push_cnt);
        check("fifo_no_overread", overreads, 0);
        check("stim_queue_empty", stim_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
